// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter
//   Round-robin arbiter that owns a single W-bit shared register. Each edge it
//   selects at most one requesting port (scan starts at the round-robin
//   pointer), copies that port's data into the register and reports the
//   one-hot grant and owner index. All outputs are registered.
//
//   Optional lock mode (define SHARED_REG_LOCK_EN): a winner that also asserts
//   lock keeps the register for up to MAX_LOCK consecutive cycles. Without the
//   macro the lock input is ignored and no lock state/counter is built.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, highest priority
//   req[N]   : level-sensitive request per port
//   lock[N]  : per-port lock request (qualified by req)
//   din[N*W] : port i data at [i*W +: W]
//   gnt[N]   : registered one-hot grant, zero when idle
//   q[W]     : shared register contents
//   q_valid  : q was written on the preceding edge
//   owner    : index of the port that last wrote q
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  output logic [$clog2(N)-1:0] owner
);

  localparam int PW = $clog2(N);

`ifdef SHARED_REG_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_e;
`else
  localparam int unused_max_lock = MAX_LOCK;
  typedef enum logic {IDLE, GRANT} state_e;
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  // Per-port data view
  logic [W-1:0] din_a [N];
  for (genvar g = 0; g < N; g++) begin : g_din
    assign din_a[g] = din[g*W +: W];
  end

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  q_q, q_d;
  logic          q_valid_q, q_valid_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] ptr_q, ptr_d;
`ifdef SHARED_REG_LOCK_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_hold;
`endif

  // Rotating priority scan: first requester at or after ptr wins.
  logic          arb_found;
  logic [PW-1:0] arb_win;
  logic [PW-1:0] arb_next;

  always_comb begin
    int          idx;
    logic [PW-1:0] cand;
    idx       = 0;
    cand      = '0;
    arb_found = 1'b0;
    arb_win   = '0;
    for (int i = 0; i < N; i++) begin
      idx  = (int'(ptr_q) + i) % N;
      cand = PW'(idx);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_win   = cand;
      end
    end
  end

  // Pointer moves past the winner; explicit wrap handles non-power-of-two N.
  assign arb_next = (arb_win == PW'(N - 1)) ? '0 : arb_win + PW'(1);

  always_comb begin
    logic do_arb;
    state_d   = state_q;
    gnt_d     = '0;
    q_d       = q_q;
    q_valid_d = 1'b0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    do_arb    = 1'b1;
`ifdef SHARED_REG_LOCK_EN
    cnt_d     = '0;
    // Burst continues while the owner keeps req+lock and the bound is not hit.
    lock_hold = req[owner_q] && lock[owner_q] && (cnt_q < CW'(MAX_LOCK - 1));
`endif

    case (state_q)
`ifdef SHARED_REG_LOCK_EN
      LOCK: begin
        if (lock_hold) begin
          do_arb    = 1'b0;
          gnt_d     = gnt_q;
          q_d       = din_a[owner_q];
          q_valid_d = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
`endif
      IDLE, GRANT: do_arb = 1'b1;
      default:     do_arb = 1'b1;
    endcase

    // Normal arbitration; also runs on the lock-exit edge so there is no bubble.
    if (do_arb) begin
      if (arb_found) begin
        gnt_d[arb_win] = 1'b1;
        q_d            = din_a[arb_win];
        q_valid_d      = 1'b1;
        owner_d        = arb_win;
        ptr_d          = arb_next;
        state_d        = GRANT;
`ifdef SHARED_REG_LOCK_EN
        if (lock[arb_win]) state_d = LOCK;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      owner_q   <= '0;
      ptr_q     <= '0;
`ifdef SHARED_REG_LOCK_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
`ifdef SHARED_REG_LOCK_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed vectors, a behavioural model that
// re-derives the outputs every cycle, and literal expectations at key points.
module tb_shared_reg_arbiter;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_LOCK = 8;
`ifdef SHARED_REG_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, lock;
  logic [N*W-1:0] din;
  logic [N-1:0] gnt;
  logic [W-1:0] q;
  logic         q_valid;
  logic [1:0]   owner;

  always #5 clk = ~clk;

  shared_reg_arbiter #(.N(N), .W(W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .din(din),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: m_held counts cycles of the current lock burst (0 = no burst)
  logic [N-1:0] m_gnt;
  logic [W-1:0] m_q;
  logic         m_qv;
  int           m_owner, m_ptr, m_held;
  bit           m_live = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_din_base();
    for (int i = 0; i < N; i++) din[i*W +: W] = 8'hA0 + 8'(i);
  endtask

  initial begin
    logic [N-1:0] tbl_req [7];
    rst  = 1'b1;
    req  = 4'b1111;
    lock = '0;
    set_din_base();

    // Model update at each edge, compare on the following falling edge.
    fork
      forever begin
        bit cont;
        int w;
        @(posedge clk);
        cont = 1'b0;
        if (rst) begin
          m_gnt = '0; m_q = '0; m_qv = 1'b0; m_owner = 0; m_ptr = 0; m_held = 0;
        end else begin
          if (LOCK_EN && m_held > 0 && req[m_owner] && lock[m_owner] && m_held < MAX_LOCK)
            cont = 1'b1;
          if (cont) begin
            m_q  = din[m_owner*W +: W];
            m_qv = 1'b1;
            m_held++;
          end else begin
            m_held = 0;
            w = pick(req, m_ptr);
            if (w >= 0) begin
              m_gnt = '0;
              m_gnt[w] = 1'b1;
              m_q = din[w*W +: W];
              m_qv = 1'b1;
              m_owner = w;
              m_ptr = (w + 1) % N;
              if (LOCK_EN && lock[w]) m_held = 1;
            end else begin
              m_gnt = '0;
              m_qv  = 1'b0;
            end
          end
        end
        m_live = 1'b1;
        @(negedge clk);
        if (m_live) begin
          n_chk++;
          if (gnt !== m_gnt) begin
            n_fail++; $display("FAIL model_gnt: got %b want %b at %0t", gnt, m_gnt, $time);
          end
          n_chk++;
          if (q !== m_q) begin
            n_fail++; $display("FAIL model_q: got %h want %h at %0t", q, m_q, $time);
          end
          n_chk++;
          if (q_valid !== m_qv) begin
            n_fail++; $display("FAIL model_q_valid: got %b want %b at %0t", q_valid, m_qv, $time);
          end
          n_chk++;
          if (int'(owner) != m_owner || $isunknown(owner)) begin
            n_fail++; $display("FAIL model_owner: got %0d want %0d at %0t", owner, m_owner, $time);
          end
        end
      end
    join_none

    // Reset holds everything at zero even with all ports requesting
    for (int e = 0; e < 2; e++) begin
      tick();
      lit("rst_gnt", 32'(gnt), 32'h0);
      lit("rst_q", 32'(q), 32'h0);
      lit("rst_qv", 32'(q_valid), 32'h0);
      lit("rst_owner", 32'(owner), 32'h0);
    end

    // Round-robin over all four ports
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      lit("rr_gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      lit("rr_q", 32'(q), 32'(8'hA0 + 8'(k % 4)));
    end

    // Sole requester, then idle
    req = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick();
      lit("solo_gnt", 32'(gnt), 32'b0100);
      lit("solo_qv", 32'(q_valid), 32'h1);
    end
    req = '0;
    tick();
    lit("idle_gnt", 32'(gnt), 32'h0);
    lit("idle_qv", 32'(q_valid), 32'h0);
    lit("idle_q_hold", 32'(q), 32'hA2);

    // Lock bound: port1 locks while port3 waits
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1010; lock = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      din[1*W +: W] = 8'h10 + 8'(k);
      tick();
      lit("lock_bound_gnt", 32'(gnt), 32'(LOCK_EN ? 4'b0010 : ((k % 2) ? 4'b1000 : 4'b0010)));
      lit("lock_bound_q", 32'(q), 32'((LOCK_EN || (k % 2 == 0)) ? 8'h10 + 8'(k) : 8'hA3));
    end
    tick();
    lit("lock_exit_gnt", 32'(gnt), 32'(LOCK_EN ? 4'b1000 : 4'b0010));
    set_din_base();

    // Early release, port2 idle -> port0 next
    rst = 1'b1; req = '0; lock = '0; tick(); rst = 1'b0;
    req = 4'b0010; lock = 4'b0010; tick();
    lit("early_first", 32'(gnt), 32'b0010);
    req = 4'b0011;
    tick();
    lit("early_hold1", 32'(gnt), 32'(LOCK_EN ? 4'b0010 : 4'b0001));
    tick();
    lit("early_hold2", 32'(gnt), 32'b0010);
    lock = '0; tick();
    lit("early_rel_p0", 32'(gnt), 32'b0001);
    tick();
    lit("early_after", 32'(gnt), 32'b0010);

    // Early release with port2 requesting -> port2 next
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    req = 4'b0010; lock = 4'b0010; tick();
    req = 4'b0011; tick(); tick();
    req = 4'b0111; lock = '0; tick();
    lit("early_rel_p2", 32'(gnt), 32'b0100);

    // Reset during the 4th locked cycle
    rst = 1'b1; req = '0; tick(); rst = 1'b0;
    req = 4'b0010; lock = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      tick();
      lit("midlock_gnt", 32'(gnt), 32'b0010);
    end
    rst = 1'b1; tick();
    lit("midlock_rst_gnt", 32'(gnt), 32'h0);
    lit("midlock_rst_q", 32'(q), 32'h0);
    lit("midlock_rst_qv", 32'(q_valid), 32'h0);
    lit("midlock_rst_owner", 32'(owner), 32'h0);
    rst = 1'b0; req = 4'b1111; lock = '0; tick();
    lit("restart_gnt", 32'(gnt), 32'b0001);

    // Mixed patterns with changing data, checked by the model
    tbl_req = '{4'b0101, 4'b1001, 4'b0000, 4'b0110, 4'b1111, 4'b1000, 4'b0011};
    for (int s = 0; s < 7; s++) begin
      req  = tbl_req[s];
      lock = 4'(s);
      for (int i = 0; i < N; i++) din[i*W +: W] = 8'(s * 16 + i * 3 + 1);
      tick();
    end
    req = '0; lock = '0; tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter that shares one W-bit storage register among N requesters. Each cycle it picks at most one requesting port, captures that port's data into the shared register and reports the grant and owner. An optional lock mode lets the winner hold the register for a bounded burst. It sits in front of the shared state element of the sequential datapath and is its only writer.

## Interface
- N, 4, number of requesters (2..16)
- W, 8, data/register width
- MAX_LOCK, 8, maximum consecutive cycles one port may hold a lock (≥1; used only with lock feature)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; sampled on rising clk edge, highest priority
- req  in  N  request per port; level-sensitive, sampled every edge
- lock  in  N  per-port lock request, meaningful only together with req
- din  in  N*W  port i data at bits [i*W +: W]
- gnt  out  N  registered one-hot grant, all-zero when idle
- q  out  W  shared register contents
- q_valid  out  1  high for each cycle in which q was written on the preceding edge
- owner  out  $clog2(N)  index of the port that last wrote q

## Operation
- Reset values: gnt=0, q=0, q_valid=0, owner=0, round-robin pointer ptr=0, lock counter=0, state IDLE.
- Arbitration: scan req starting at index ptr, ascending mod N; first set bit wins. On a win at edge k: gnt=onehot(win), q=din[win], q_valid=1, owner=win, ptr=(win+1) mod N.
- No request: gnt=0, q_valid=0, q/owner/ptr hold.
- States:
  - IDLE: no grant. If any req, arbitrate and go to GRANT or LOCK; otherwise stay in IDLE.
  - GRANT: single-cycle grant. Re-arbitrate on every edge. The same port may win again only if no other port is requesting, because ptr has already advanced.
  - LOCK: entered when the winner has lock[win]=1 at its grant edge. On each edge while req[owner]&lock[owner] and count<MAX_LOCK-1: gnt holds, q=din[owner], q_valid=1, count++.
- Lock exit: req[owner]=0, lock[owner]=0, or count reached MAX_LOCK-1. On that edge, normal arbitration from ptr=owner+1 runs immediately (no bubble) and count=0.
- Other ports' requests are ignored during LOCK and are not lost, because req is level-sensitive.
- Simultaneous requests resolve by ptr order only; lock bits never affect the winner choice.
- N not a power of two: ptr wraps N-1 → 0; owner never exceeds N-1.
- Reset asserted in any state, including mid-lock: all outputs go to reset values on that edge. No grant is issued on that edge.

## Timing
- Latency 1: req/din sampled at edge k appear as gnt/q/q_valid/owner after edge k.
- gnt, q, q_valid and owner are registered outputs; there is no combinational path from inputs to outputs.
- Throughput: one write per cycle. A port can be granted every cycle only when it is the sole requester or while it holds a lock.
- Worst-case wait without locks is N-1 cycles; with locks it is (N-1)*MAX_LOCK cycles.

## Configuration
- SHARED_REG_LOCK_EN defined: LOCK state, lock counter and MAX_LOCK bounding are present as described above.
- SHARED_REG_LOCK_EN undefined: the lock input is ignored and the LOCK state and counter are not built. Every grant is single-cycle GRANT behaviour. Port list is unchanged.

## Test plan
- Reset: drive req=4'b1111 with rst=1 for 2 edges → gnt=0, q=0, q_valid=0, owner=0 throughout; first edge after release → gnt=4'b0001, owner=0.
- Round-robin fairness (N=4): hold req=4'b1111 with din[i]=8'hA0+i → gnt sequence 0001, 0010, 0100, 1000, 0001; q sequence A0, A1, A2, A3, A0.
- Single requester and idle: only req[2]=1 for 3 edges, then req=0 → gnt=0100 for 3 cycles with q_valid=1, then gnt=0 and q_valid=0 while q holds its last value.
- Lock bound (with SHARED_REG_LOCK_EN, MAX_LOCK=8): port1 holds req and lock while port3 also requests → gnt=0010 for exactly 8 cycles, then gnt=1000 on the next cycle.
- Lock early release: drop lock[1] after 3 locked cycles while req[0]=1 → the next grant goes to port 2 if it requests, otherwise port 0. Without SHARED_REG_LOCK_EN, the same stimulus alternates grants every cycle.
- Reset mid-lock: assert rst during the 4th locked cycle → all outputs reach reset values on that edge; after release, arbitration restarts from port 0.
